// File: rtl/alu_div_seq.sv
// alu_div_seq
//   Multi-cycle restoring divider for the EX stage. It takes over the shared
//   32-bit ALU in subtract mode for ITER cycles, one quotient bit per cycle,
//   and handles signed and unsigned divides. It holds the pipeline while the
//   divide runs.
//
//   State table:
//     S_IDLE | waiting for start; latches operands and magnitudes
//     S_RUN  | one shift-subtract iteration per cycle through the shared ALU
//     S_FIN  | results valid, done pulses, pipeline released
//
// Ports:
//   clk, reset               clock; synchronous active-high reset
//   start, signed_op         divide request and signedness (sampled in IDLE)
//   dividend, divisor        operands (sampled with start)
//   alu_sel                  1 = ALU operands/Signal come from this block
//   alu_signal               ALU Signal code (always SUB_CODE)
//   alu_dataA, alu_dataB     ALU operands while alu_sel=1, otherwise 0
//   alu_result               ALU dataOut
//   busy, stall, done        status: not idle, pipeline hold, result pulse
//   quotient, remainder      results, held until the next accepted start
module alu_div_seq #(
  parameter logic [2:0] SUB_CODE = 3'b110,
  parameter int         ITER     = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        alu_sel,
  output logic [2:0]  alu_signal,
  output logic [31:0] alu_dataA,
  output logic [31:0] alu_dataB,
  input  logic [31:0] alu_result,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  localparam int            CW       = $clog2(ITER);
  localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t        state_q, state_d;
  logic [31:0]   r_q, r_d;
  logic [31:0]   q_q, q_d;
  logic [31:0]   d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          q_neg_q, q_neg_d;
  logic          r_neg_q, r_neg_d;
  logic [31:0]   quotient_q, quotient_d;
  logic [31:0]   remainder_q, remainder_d;

  logic [31:0]   a_mag, b_mag;
  logic [31:0]   rs;
  logic          r_msb, borrow, sub_ok;
  logic [31:0]   r_nx, q_nx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      q_q         <= q_d;
      d_q         <= d_d;
      cnt_q       <= cnt_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    q_d         = q_q;
    d_d         = d_q;
    cnt_d       = cnt_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;

    alu_sel     = 1'b0;
    alu_signal  = SUB_CODE;
    alu_dataA   = '0;
    alu_dataB   = '0;
    stall       = 1'b0;

    // Magnitudes use a local negate so the ALU stays free for the pipeline.
    a_mag = (signed_op && dividend[31]) ? (~dividend + 32'd1) : dividend;
    b_mag = (signed_op && divisor[31])  ? (~divisor  + 32'd1) : divisor;

    // 33-bit shifted remainder {r_msb, rs}; the ALU only sees the low 32 bits,
    // so the unsigned borrow is rebuilt from the operand and result MSBs.
    r_msb  = r_q[31];
    rs     = {r_q[30:0], q_q[31]};
    borrow = (~rs[31] & d_q[31]) | (~(rs[31] ^ d_q[31]) & alu_result[31]);
    sub_ok = r_msb | ~borrow;
    r_nx   = sub_ok ? alu_result : rs;
    q_nx   = {q_q[30:0], sub_ok};

    unique case (state_q)
      S_IDLE: begin
        stall = start;
        if (start) begin
          if (divisor == 32'd0) begin
            quotient_d  = 32'hFFFF_FFFF;
            remainder_d = dividend;
            state_d     = S_FIN;
          end else begin
            q_d     = a_mag;
            r_d     = '0;
            d_d     = b_mag;
            cnt_d   = '0;
            q_neg_d = signed_op & (dividend[31] ^ divisor[31]);
            r_neg_d = signed_op & dividend[31];
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        alu_sel   = 1'b1;
        alu_dataA = rs;
        alu_dataB = d_q;
        stall     = 1'b1;
        r_d       = r_nx;
        q_d       = q_nx;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          // Results land on the edge into FIN so they are visible with done.
          quotient_d  = q_neg_q ? (~q_nx + 32'd1) : q_nx;
          remainder_d = r_neg_q ? (~r_nx + 32'd1) : r_nx;
          state_d     = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FIN);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule
